// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM encoding and the
// classification of which operations take the iterative path.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_SHR  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIVU = 4'd10;
  localparam logic [3:0] ALU_MODU = 4'd11;
  localparam logic [3:0] ALU_PASS = 4'd12;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIVU) || (op == ALU_MODU);
  endfunction

  // Division by zero short-circuits to a single-cycle saturated result.
  function automatic logic needs_iter(input logic [3:0] op, input logic b_is_zero);
    return (op == ALU_MUL) || (is_div_op(op) && !b_is_zero);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative engine: 16-step unsigned shift-add multiply on operand magnitudes
// with a final sign fix, and 16-step restoring unsigned division.
module seq_muldiv #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder
);
  localparam int CW = $clog2(W);

  logic           r_active;
  logic           r_is_div;
  logic           r_neg;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_divisor;

  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_acc_next;
  logic [W:0]     w_rem_shift;
  logic [W:0]     w_diff;
  logic           w_ge;
  logic [W-1:0]   w_rem_next;
  logic [W-1:0]   w_quo_next;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;

  // The partial remainder is always below the divisor, so the borrow bit of
  // the trial subtraction alone decides the quotient bit.
  assign w_rem_shift = {r_rem, r_quo[W-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_divisor};
  assign w_ge        = ~w_diff[W];
  assign w_rem_next  = w_ge ? w_diff[W-1:0] : w_rem_shift[W-1:0];
  assign w_quo_next  = {r_quo[W-2:0], w_ge};

  // Results reflect the step being taken this cycle, so the final write can
  // happen on the same edge as the last iteration.
  assign done      = r_active && (r_cnt == CW'(W - 1));
  assign product   = r_neg ? -w_acc_next : w_acc_next;
  assign quotient  = w_quo_next;
  assign remainder = w_rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
    end else if (start) begin
      r_active  <= 1'b1;
      r_is_div  <= is_div;
      r_neg     <= a[W-1] ^ b[W-1];
      r_cnt     <= '0;
      r_mcand   <= {{W{1'b0}}, mag(a)};
      r_mplier  <= mag(b);
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= a;
      r_divisor <= b;
    end else if (r_active) begin
      if (r_is_div) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
      end else begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      r_cnt <= r_cnt + CW'(1);
      if (done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU behind a level request/done handshake: single-cycle ops
// finish in one EXEC cycle, MUL/DIVU/MODU run through seq_muldiv.
module seq_alu #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_incoming,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic             signov,
  output logic             alu_done
);
  import alu_pkg::*;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic             r_signov;

  logic             w_accept;
  logic             w_iter;
  logic             w_md_done;
  logic [2*WIDTH-1:0] w_md_product;
  logic [WIDTH-1:0] w_md_quotient;
  logic [WIDTH-1:0] w_md_remainder;
  logic [WIDTH-1:0] w_mul_hi;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_sra;
  logic             w_amt_zero;

  logic [WIDTH-1:0] w_sc_y;
  logic             w_sc_c;
  logic             w_sc_v;
  logic [WIDTH-1:0] w_it_y;
  logic             w_it_v;

  assign w_accept = (r_state == S_IDLE) && alu_incoming;
  assign w_iter   = needs_iter(r_op, r_b == '0);

  seq_muldiv #(.W(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_accept),
    .is_div    (is_div_op(alu_op)),
    .a         (A),
    .b         (B),
    .done      (w_md_done),
    .product   (w_md_product),
    .quotient  (w_md_quotient),
    .remainder (w_md_remainder)
  );

  assign w_add      = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub      = {1'b0, r_a} - {1'b0, r_b};
  assign w_shl      = {1'b0, r_a} << r_b[3:0];
  assign w_shr      = {r_a, 1'b0} >> r_b[3:0];
  assign w_sra      = $signed({r_a, 1'b0}) >>> r_b[3:0];
  assign w_amt_zero = (r_b[3:0] == 4'd0);

  always_comb begin
    w_sc_y = '0;
    w_sc_c = 1'b0;
    w_sc_v = 1'b0;
    case (r_op)
      ALU_ADD: begin
        w_sc_y = w_add[WIDTH-1:0];
        w_sc_c = w_add[WIDTH];
        w_sc_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_sc_y = w_sub[WIDTH-1:0];
        w_sc_c = w_sub[WIDTH];
        w_sc_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
      end
      ALU_AND:  w_sc_y = r_a & r_b;
      ALU_OR:   w_sc_y = r_a | r_b;
      ALU_XOR:  w_sc_y = r_a ^ r_b;
      ALU_NOT:  w_sc_y = ~r_a;
      ALU_PASS: w_sc_y = r_a;
      ALU_SHL: begin
        w_sc_y = w_shl[WIDTH-1:0];
        w_sc_c = w_shl[WIDTH] && !w_amt_zero;
      end
      ALU_SHR: begin
        w_sc_y = w_shr[WIDTH:1];
        w_sc_c = w_shr[0] && !w_amt_zero;
      end
      ALU_SRA: begin
        w_sc_y = w_sra[WIDTH:1];
        w_sc_c = w_sra[0] && !w_amt_zero;
      end
      // Only reached here with a zero divisor.
      ALU_DIVU, ALU_MODU: begin
        w_sc_y = '1;
        w_sc_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_mul_hi = w_md_product[2*WIDTH-1:WIDTH];

  always_comb begin
    w_it_y = w_md_product[WIDTH-1:0];
    w_it_v = 1'b0;
    case (r_op)
      ALU_DIVU: w_it_y = w_md_quotient;
      ALU_MODU: w_it_y = w_md_remainder;
      // The product fits in WIDTH signed bits only if the high half is a
      // pure sign extension of the low half's MSB.
      default:  w_it_v = ~((&w_mul_hi && w_md_product[WIDTH-1]) ||
                           (~|w_mul_hi && !w_md_product[WIDTH-1]));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_y      <= '0;
      r_carry  <= 1'b0;
      r_signov <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (alu_incoming) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= alu_op;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!alu_incoming) begin
            r_state <= S_IDLE;
          end else if (w_iter) begin
            if (w_md_done) begin
              r_y      <= w_it_y;
              r_carry  <= 1'b0;
              r_signov <= w_it_v;
              r_state  <= S_DONE;
            end
          end else begin
            r_y      <= w_sc_y;
            r_carry  <= w_sc_c;
            r_signov <= w_sc_v;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!alu_incoming) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Y        = r_y;
  assign carry    = r_carry;
  assign signov   = r_signov;
  assign alu_done = (r_state == S_DONE);

endmodule
